// File: rtl/bulk_ep_out_if.sv
// Bulk OUT endpoint signal bundle.
//   USB side : xfer / ready (ACK-NAK hint), byte stream tvalid/tready/tlast/tdata,
//              CRC verdict pulses ok / err.
//   User side: committed byte stream m_tvalid/m_tready/m_tlast/m_tdata, level.
// Modports:
//   slave  - the endpoint buffer (bulk_ep_out)
//   master - whoever drives the USB engine and user sides (engine / bench)
interface bulk_ep_out_if #(
    parameter int ABITS = 11
);
    logic             bulk_ep_out_xfer_i;
    logic             bulk_ep_out_ready_o;
    logic             bulk_ep_out_tvalid_i;
    logic             bulk_ep_out_tready_o;
    logic             bulk_ep_out_tlast_i;
    logic [7:0]       bulk_ep_out_tdata_i;
    logic             bulk_ep_out_ok_i;
    logic             bulk_ep_out_err_i;
    logic             m_tvalid_o;
    logic             m_tready_i;
    logic             m_tlast_o;
    logic [7:0]       m_tdata_o;
    logic [ABITS:0]   level_o;

    modport slave (
        input  bulk_ep_out_xfer_i, bulk_ep_out_tvalid_i, bulk_ep_out_tlast_i,
               bulk_ep_out_tdata_i, bulk_ep_out_ok_i, bulk_ep_out_err_i, m_tready_i,
        output bulk_ep_out_ready_o, bulk_ep_out_tready_o, m_tvalid_o, m_tlast_o,
               m_tdata_o, level_o
    );

    modport master (
        output bulk_ep_out_xfer_i, bulk_ep_out_tvalid_i, bulk_ep_out_tlast_i,
               bulk_ep_out_tdata_i, bulk_ep_out_ok_i, bulk_ep_out_err_i, m_tready_i,
        input  bulk_ep_out_ready_o, bulk_ep_out_tready_o, m_tvalid_o, m_tlast_o,
               m_tdata_o, level_o
    );
endinterface

// File: rtl/bulk_ep_out.sv
// Bulk OUT endpoint buffer (host -> device).
// Packet bytes from the USB engine are written speculatively into a DEPTH x 9b
// RAM ({last,data}); the CRC verdict either commits them (cm_ptr <= wr_ptr) or
// rolls them back (wr_ptr <= cm_ptr). Only committed bytes are streamed to the
// user through a FWFT read path (RAM read stage + output register).
// Ports:
//   clock, reset       - single clock, synchronous active-high reset
//   bus (slave)        - USB side: xfer, ready (ACK/NAK), tvalid/tready/tlast/tdata,
//                        ok/err verdict pulses; user side: m_tvalid/m_tready/
//                        m_tlast/m_tdata, level (committed bytes not yet read)
// Parameters: ABITS (log2 depth), MAX_PACKET (<= DEPTH/2).
// Build option: BULK_OUT_SHORT_TLAST_EN - when defined, the stored last bit only
//   marks short packets (end of a USB transfer) instead of every packet end.
module bulk_ep_out #(
    parameter int ABITS      = 11,
    parameter int MAX_PACKET = 512
) (
    input logic            clock,
    input logic            reset,
    bulk_ep_out_if.slave   bus
);
    localparam int             DEPTH   = 2 ** ABITS;
    localparam logic [ABITS:0] DEPTH_P = (ABITS + 1)'(DEPTH);
    localparam logic [ABITS:0] MAXP    = (ABITS + 1)'(MAX_PACKET);

    typedef enum logic [2:0] {IDLE, RECV, WAIT, DROP, NAK} state_t;

    state_t         state, state_nxt;
    logic           xfer_q;
    logic           boot;          // holds ready low in the cycle after reset
    logic [ABITS:0] wr_ptr, cm_ptr, rd_ptr, fe_ptr;
    logic [ABITS:0] count;
    logic [ABITS:0] used;
    logic [8:0]     mem [DEPTH];

    logic xfer_rise, xfer_fall, stop_rx, room_ok;
    logic ready, tready, wr_en, commit, rollback;
    logic last_bit;

    // read path
    logic       s1_vld, m_vld, m_last;
    logic [8:0] s1_data;
    logic [7:0] m_data;
    logic       pop, m_load, issue;

    assign xfer_rise = bus.bulk_ep_out_xfer_i & ~xfer_q;
    assign xfer_fall = ~bus.bulk_ep_out_xfer_i & xfer_q;
    // Any verdict or end of data stage terminates reception.
    assign stop_rx   = bus.bulk_ep_out_ok_i | bus.bulk_ep_out_err_i | xfer_fall;
    assign used      = wr_ptr - rd_ptr;
    assign room_ok   = (used <= DEPTH_P - MAXP);

`ifdef BULK_OUT_SHORT_TLAST_EN
    // A full-size packet never ends a transfer, so its last byte is not marked.
    assign last_bit = bus.bulk_ep_out_tlast_i && ((count + 1'b1) < MAXP);
`else
    assign last_bit = bus.bulk_ep_out_tlast_i;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (xfer_rise) state_nxt = ready ? RECV : NAK;
            RECV: begin
                if (stop_rx)
                    state_nxt = IDLE;
                else if (bus.bulk_ep_out_tvalid_i) begin
                    if (count == MAXP)                 state_nxt = DROP;
                    else if (bus.bulk_ep_out_tlast_i)  state_nxt = WAIT;
                end
            end
            WAIT: if (stop_rx) state_nxt = IDLE;
            DROP: if (stop_rx) state_nxt = IDLE;
            NAK:  if (!bus.bulk_ep_out_xfer_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ready    = 1'b0;
        tready   = 1'b0;
        wr_en    = 1'b0;
        commit   = 1'b0;
        rollback = 1'b0;
        unique case (state)
            IDLE: ready = room_ok & ~boot;
            RECV: begin
                tready   = 1'b1;
                wr_en    = ~stop_rx & bus.bulk_ep_out_tvalid_i & (count != MAXP);
                // A ZLP (ok with nothing stored) rolls back to an identical pointer.
                rollback = stop_rx;
            end
            WAIT: begin
                // err or the end of the data stage override a simultaneous ok
                rollback = bus.bulk_ep_out_err_i | xfer_fall;
                commit   = bus.bulk_ep_out_ok_i & ~rollback;
            end
            DROP: begin
                tready   = 1'b1;
                rollback = stop_rx;
            end
            default: ;
        endcase
    end

    // ---------------- write side ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            xfer_q <= 1'b0;
            boot   <= 1'b1;
            wr_ptr <= '0;
            cm_ptr <= '0;
            count  <= '0;
        end else begin
            xfer_q <= bus.bulk_ep_out_xfer_i;
            boot   <= 1'b0;
            if (state == IDLE && xfer_rise) count <= '0;
            else if (wr_en)                 count <= count + 1'b1;
            if (rollback)   wr_ptr <= cm_ptr;
            else if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (commit)     cm_ptr <= wr_ptr;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr[ABITS-1:0]] <= {last_bit, bus.bulk_ep_out_tdata_i};
    end

    // ---------------- read side ----------------
    // fe_ptr runs ahead of rd_ptr by the bytes held in the read pipeline;
    // rd_ptr only counts bytes the user has actually taken.
    assign pop    = m_vld & bus.m_tready_i;
    assign m_load = s1_vld & (~m_vld | pop);
    assign issue  = (fe_ptr != cm_ptr) & (~s1_vld | m_load);

    always_ff @(posedge clock) begin
        if (issue) s1_data <= mem[fe_ptr[ABITS-1:0]];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fe_ptr <= '0;
            rd_ptr <= '0;
            s1_vld <= 1'b0;
            m_vld  <= 1'b0;
            m_last <= 1'b0;
            m_data <= '0;
        end else begin
            if (issue) begin
                fe_ptr <= fe_ptr + 1'b1;
                s1_vld <= 1'b1;
            end else if (m_load) begin
                s1_vld <= 1'b0;
            end
            if (m_load) begin
                m_vld  <= 1'b1;
                m_last <= s1_data[8];
                m_data <= s1_data[7:0];
            end else if (pop) begin
                m_vld  <= 1'b0;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign bus.bulk_ep_out_ready_o  = ready;
    assign bus.bulk_ep_out_tready_o = tready;
    assign bus.m_tvalid_o           = m_vld;
    assign bus.m_tlast_o            = m_last;
    assign bus.m_tdata_o            = m_data;
    assign bus.level_o              = cm_ptr - rd_ptr;
endmodule

// File: tb/tb_bulk_ep_out.sv
// Self-checking bench for bulk_ep_out: directed packets, expected user-stream
// bytes queued at stimulus time and checked by a forked monitor.
module tb_bulk_ep_out;
    localparam int ABITS = 11;
    localparam int MP    = 512;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bulk_ep_out_if #(.ABITS(ABITS)) bus ();

    bulk_ep_out #(.ABITS(ABITS), .MAX_PACKET(MP)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    logic [8:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (bus.m_tvalid_o === 1'b1 && bus.m_tready_i === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL stream: unexpected byte %h last %b", bus.m_tdata_o, bus.m_tlast_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.m_tlast_o, bus.m_tdata_o} !== e) begin
                        n_err++;
                        $display("FAIL stream: got last=%b data=%h expected last=%b data=%h",
                                 bus.m_tlast_o, bus.m_tdata_o, e[8], e[7:0]);
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pkt(input int n, input int base);
        logic last;
        for (int i = 0; i < n; i++) begin
            last = (i == n - 1);
`ifdef BULK_OUT_SHORT_TLAST_EN
            last = last && (n < MP);
`endif
            exp_q.push_back({last, 8'(base + i)});
        end
    endtask

    task automatic beats(input int n, input int base, input bit tl);
        for (int i = 0; i < n; i++) begin
            bus.bulk_ep_out_tvalid_i = 1'b1;
            bus.bulk_ep_out_tdata_i  = 8'(base + i);
            bus.bulk_ep_out_tlast_i  = tl && (i == n - 1);
            tick();
        end
        bus.bulk_ep_out_tvalid_i = 1'b0;
        bus.bulk_ep_out_tlast_i  = 1'b0;
    endtask

    task automatic send_ok(input int n, input int base, input bit push);
        if (push) push_pkt(n, base);
        bus.bulk_ep_out_xfer_i = 1'b1;
        tick();
        beats(n, base, 1'b1);
        bus.bulk_ep_out_ok_i = 1'b1;
        tick();
        bus.bulk_ep_out_ok_i   = 1'b0;
        bus.bulk_ep_out_xfer_i = 1'b0;
        tick();
    endtask

    // exactly n user pops, then m_tready back low
    task automatic drain(input int n);
        int got = 0;
        int budget = 0;
        bus.m_tready_i = 1'b1;
        while (got < n && budget < 5000) begin
            @(negedge clk);
            if (bus.m_tvalid_o) got++;
            budget++;
        end
        @(posedge clk);
        #1;
        bus.m_tready_i = 1'b0;
        chk("drain_count", got, n);
    endtask

    task automatic wait_drain(input string name);
        int b = 0;
        bus.m_tready_i = 1'b1;
        while ((exp_q.size() != 0 || bus.m_tvalid_o) && b < 5000) begin
            tick();
            b++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        bus.bulk_ep_out_xfer_i   = 1'b0;
        bus.bulk_ep_out_tvalid_i = 1'b0;
        bus.bulk_ep_out_tlast_i  = 1'b0;
        bus.bulk_ep_out_tdata_i  = 8'h00;
        bus.bulk_ep_out_ok_i     = 1'b0;
        bus.bulk_ep_out_err_i    = 1'b0;
        bus.m_tready_i           = 1'b0;
        fork
            monitor();
        join_none

        // ---- reset state ----
        tick();
        tick();
        chk("rst_ready", bus.bulk_ep_out_ready_o, 0);
        chk("rst_tready", bus.bulk_ep_out_tready_o, 0);
        chk("rst_m_tvalid", bus.m_tvalid_o, 0);
        chk("rst_m_tlast", bus.m_tlast_o, 0);
        chk("rst_m_tdata", bus.m_tdata_o, 0);
        chk("rst_level", bus.level_o, 0);
        rst = 1'b0;
        tick();
        tick();
        chk("ready_after_rst", bus.bulk_ep_out_ready_o, 1);

        // ---- 64-byte packet, commit, FWFT latency ----
        bus.m_tready_i = 1'b1;
        push_pkt(64, 8'h10);
        bus.bulk_ep_out_xfer_i = 1'b1;
        tick();
        chk("recv_tready", bus.bulk_ep_out_tready_o, 1);
        beats(64, 8'h10, 1'b1);
        chk("wait_tready", bus.bulk_ep_out_tready_o, 0);
        chk("pre_commit_level", bus.level_o, 0);
        bus.bulk_ep_out_ok_i = 1'b1;
        tick();
        bus.bulk_ep_out_ok_i = 1'b0;
        chk("commit_level", bus.level_o, 64);
        chk("lat_c0_tvalid", bus.m_tvalid_o, 0);
        tick();
        chk("lat_c1_tvalid", bus.m_tvalid_o, 0);
        tick();
        chk("lat_c2_tvalid", bus.m_tvalid_o, 1);
        chk("lat_c2_tdata", bus.m_tdata_o, 8'h10);
        bus.bulk_ep_out_xfer_i = 1'b0;
        wait_drain("t1_drain");
        chk("t1_level_end", bus.level_o, 0);

        // ---- 100-byte packet, CRC error: nothing out ----
        bus.bulk_ep_out_xfer_i = 1'b1;
        tick();
        beats(100, 8'h40, 1'b1);
        bus.bulk_ep_out_err_i = 1'b1;
        tick();
        bus.bulk_ep_out_err_i = 1'b0;
        chk("err_ready", bus.bulk_ep_out_ready_o, 1);
        chk("err_level", bus.level_o, 0);
        bus.bulk_ep_out_xfer_i = 1'b0;
        tick();
        // ok and err together: err wins
        bus.bulk_ep_out_xfer_i = 1'b1;
        tick();
        beats(10, 8'h80, 1'b1);
        bus.bulk_ep_out_ok_i  = 1'b1;
        bus.bulk_ep_out_err_i = 1'b1;
        tick();
        bus.bulk_ep_out_ok_i  = 1'b0;
        bus.bulk_ep_out_err_i = 1'b0;
        chk("okerr_level", bus.level_o, 0);
        bus.bulk_ep_out_xfer_i = 1'b0;
        tick();
        // zero-length packet
        bus.bulk_ep_out_xfer_i = 1'b1;
        tick();
        bus.bulk_ep_out_ok_i = 1'b1;
        tick();
        bus.bulk_ep_out_ok_i = 1'b0;
        chk("zlp_ready", bus.bulk_ep_out_ready_o, 1);
        chk("zlp_level", bus.level_o, 0);
        bus.bulk_ep_out_xfer_i = 1'b0;
        repeat (5) tick();
        chk("t2_no_output", bus.m_tvalid_o, 0);

        // ---- fill with user stalled; ready needs a whole max packet of space ----
        bus.m_tready_i = 1'b0;
        for (int k = 0; k < 3; k++) send_ok(MP, 3 * k, 1'b1);
        chk("fill3_level", bus.level_o, 1536);
        chk("fill3_ready", bus.bulk_ep_out_ready_o, 1);
        send_ok(MP, 8'h33, 1'b1);
        chk("fill4_level", bus.level_o, 2048);
        chk("fill4_ready", bus.bulk_ep_out_ready_o, 0);
        bus.bulk_ep_out_xfer_i   = 1'b1;
        tick();
        bus.bulk_ep_out_tvalid_i = 1'b1;
        bus.bulk_ep_out_tdata_i  = 8'hEE;
        tick();
        chk("nak_tready_a", bus.bulk_ep_out_tready_o, 0);
        tick();
        chk("nak_tready_b", bus.bulk_ep_out_tready_o, 0);
        chk("nak_ready", bus.bulk_ep_out_ready_o, 0);
        bus.bulk_ep_out_tvalid_i = 1'b0;
        bus.bulk_ep_out_xfer_i   = 1'b0;
        tick();
        chk("nak_level", bus.level_o, 2048);
        drain(511);
        chk("free511_ready", bus.bulk_ep_out_ready_o, 0);
        chk("free511_level", bus.level_o, 1537);
        drain(1);
        chk("free512_ready", bus.bulk_ep_out_ready_o, 1);
        chk("free512_level", bus.level_o, 1536);
        wait_drain("t3_drain");
        chk("t3_level_end", bus.level_o, 0);

        // ---- overflow: 513 beats without tlast ----
        bus.bulk_ep_out_xfer_i = 1'b1;
        tick();
        beats(513, 8'h20, 1'b0);
        chk("drop_tready", bus.bulk_ep_out_tready_o, 1);
        beats(3, 8'h70, 1'b0);
        bus.bulk_ep_out_ok_i = 1'b1;
        tick();
        bus.bulk_ep_out_ok_i = 1'b0;
        chk("drop_level", bus.level_o, 0);
        chk("drop_ready", bus.bulk_ep_out_ready_o, 1);
        bus.bulk_ep_out_xfer_i = 1'b0;
        repeat (5) tick();
        chk("drop_no_output", bus.m_tvalid_o, 0);
        send_ok(20, 8'h55, 1'b1);
        wait_drain("t4_drain");

        // ---- 512 + 512 + 10: tlast placement ----
        send_ok(MP, 8'h01, 1'b1);
        send_ok(MP, 8'h02, 1'b1);
        send_ok(10, 8'h03, 1'b1);
        wait_drain("t5_drain");

        // ---- reset mid-RECV with committed bytes unread ----
        bus.m_tready_i = 1'b0;
        send_ok(2, 8'h90, 1'b0);
        repeat (3) tick();
        chk("pre_rst_tvalid", bus.m_tvalid_o, 1);
        chk("pre_rst_level", bus.level_o, 2);
        bus.bulk_ep_out_xfer_i = 1'b1;
        tick();
        beats(3, 8'hB0, 1'b0);
        rst = 1'b1;
        bus.bulk_ep_out_xfer_i = 1'b0;
        tick();
        chk("mid_rst_tvalid", bus.m_tvalid_o, 0);
        chk("mid_rst_tdata", bus.m_tdata_o, 0);
        chk("mid_rst_tlast", bus.m_tlast_o, 0);
        chk("mid_rst_level", bus.level_o, 0);
        chk("mid_rst_ready", bus.bulk_ep_out_ready_o, 0);
        chk("mid_rst_tready", bus.bulk_ep_out_tready_o, 0);
        rst = 1'b0;
        tick();
        tick();
        bus.m_tready_i = 1'b1;
        repeat (10) tick();
        chk("post_rst_no_output", bus.m_tvalid_o, 0);
        send_ok(3, 8'hA0, 1'b1);
        wait_drain("t6_drain");

        chk("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
